// File: rtl/alu_cmd_sequencer.sv
// Front-end for the serial ALU: one packed command in, start/op/inbus sequence out,
// two result bytes captured, one packed response returned. Optional: ALU_SEQ_DIVZERO_CHECK_EN.
module alu_cmd_sequencer #(
    parameter int unsigned DW             = 8,
    parameter int unsigned FINISH_TIMEOUT = 64
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_cmd_valid,
    output logic            o_cmd_ready,
    input  logic [1:0]      i_cmd_op,
    input  logic [2*DW-1:0] i_cmd_x,
    input  logic [DW-1:0]   i_cmd_y,
    output logic            o_alu_start,
    output logic [1:0]      o_alu_op,
    output logic [DW-1:0]   o_alu_inbus,
    input  logic            i_alu_finish,
    input  logic [DW-1:0]   i_alu_outbus,
    output logic            o_rsp_valid,
    input  logic            i_rsp_ready,
    output logic [2*DW-1:0] o_rsp_data,
    output logic [1:0]      o_rsp_op,
    output logic [1:0]      o_rsp_err,
    output logic            o_busy
);

    localparam int unsigned CW = (FINISH_TIMEOUT > 1) ? $clog2(FINISH_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FINISH_TIMEOUT - 1);
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [2:0] {
        StIdle, StStart, StOp1, StOp2, StOp3, StWait, StCapLo, StResp
    } state_t;

    state_t            r_state;
    logic [1:0]        r_op;
    logic [2*DW-1:0]   r_x;
    logic [DW-1:0]     r_y;
    logic [CW-1:0]     r_cnt;
    logic              r_cmd_ready;
    logic              r_alu_start;
    logic [1:0]        r_alu_op;
    logic [DW-1:0]     r_alu_inbus;
    logic              r_rsp_valid;
    logic [2*DW-1:0]   r_rsp_data;
    logic [1:0]        r_rsp_op;
    logic [1:0]        r_rsp_err;
    logic              r_busy;

    logic              w_is_div;
    logic              w_reject;

    assign w_is_div = (r_op == OP_DIV);

`ifdef ALU_SEQ_DIVZERO_CHECK_EN
    // Zero divisor or a quotient that cannot fit in DW bits never reaches the ALU.
    assign w_reject = (i_cmd_op == OP_DIV) &&
                      ((i_cmd_y == '0) || (i_cmd_x[2*DW-1:DW] >= i_cmd_y));
`else
    assign w_reject = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_op        <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_cnt       <= '0;
            r_cmd_ready <= 1'b1;
            r_alu_start <= 1'b0;
            r_alu_op    <= '0;
            r_alu_inbus <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_op    <= '0;
            r_rsp_err   <= '0;
            r_busy      <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_cmd_valid) begin
                        r_op        <= i_cmd_op;
                        r_x         <= i_cmd_x;
                        r_y         <= i_cmd_y;
                        r_rsp_err   <= '0;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (w_reject) begin
                            r_rsp_data  <= '0;
                            r_rsp_err   <= 2'b10;
                            r_rsp_op    <= i_cmd_op;
                            r_rsp_valid <= 1'b1;
                            r_state     <= StResp;
                        end else begin
                            r_alu_start <= 1'b1;
                            r_alu_op    <= i_cmd_op;
                            r_state     <= StStart;
                        end
                    end
                end
                StStart: begin
                    r_alu_start <= 1'b0;
                    r_alu_inbus <= w_is_div ? r_x[2*DW-1:DW] : r_x[DW-1:0];
                    r_state     <= StOp1;
                end
                StOp1: begin
                    r_alu_inbus <= w_is_div ? r_x[DW-1:0] : r_y;
                    r_state     <= StOp2;
                end
                StOp2: begin
                    if (w_is_div) begin
                        r_alu_inbus <= r_y;
                        r_state     <= StOp3;
                    end else begin
                        r_alu_inbus <= '0;
                        r_cnt       <= '0;
                        r_state     <= StWait;
                    end
                end
                StOp3: begin
                    r_alu_inbus <= '0;
                    r_cnt       <= '0;
                    r_state     <= StWait;
                end
                StWait: begin
                    // Finish wins over a timeout landing in the same cycle.
                    if (i_alu_finish) begin
                        r_rsp_data[2*DW-1:DW] <= i_alu_outbus;
                        r_state               <= StCapLo;
                    end else if (r_cnt == CNT_LAST) begin
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 2'b01;
                        r_rsp_op    <= r_op;
                        r_rsp_valid <= 1'b1;
                        r_state     <= StResp;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StCapLo: begin
                    r_rsp_data[DW-1:0] <= i_alu_outbus;
                    r_rsp_op           <= r_op;
                    r_rsp_valid        <= 1'b1;
                    r_state            <= StResp;
                end
                StResp: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_alu_op    <= '0;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_cmd_ready = r_cmd_ready;
    assign o_alu_start = r_alu_start;
    assign o_alu_op    = r_alu_op;
    assign o_alu_inbus = r_alu_inbus;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;
    assign o_rsp_op    = r_rsp_op;
    assign o_rsp_err   = r_rsp_err;
    assign o_busy      = r_busy;

endmodule
